// File: rtl/fpu_align_add_if.sv
// Operation type and the handshake/operand bus of the FPU align-and-add stage.
// Master drives operands and accepts results; slave is the align/add stage.
package fpu_align_add_pkg;
    typedef enum logic {
        FPU_ADD = 1'b0,
        FPU_SUB = 1'b1
    } fpuOp_t;
endpackage

interface fpu_align_add_if #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned EXP_WIDTH = 5,
    parameter int unsigned SIG_WIDTH = 10
);
    import fpu_align_add_pkg::*;

    fpuOp_t                 op;
    logic [BIT_WIDTH-1:0]   a;
    logic [BIT_WIDTH-1:0]   b;
    logic                   inValid;
    logic                   inReady;
    logic                   outValid;
    logic                   outReady;
    logic                   outSign;
    logic [SIG_WIDTH:0]     extSigOut;
    logic [EXP_WIDTH-1:0]   adjExp;
    logic                   sticky;

    modport master (
        output op, a, b, inValid, outReady,
        input  inReady, outValid, outSign, extSigOut, adjExp, sticky
    );

    modport slave (
        input  op, a, b, inValid, outReady,
        output inReady, outValid, outSign, extSigOut, adjExp, sticky
    );
endinterface

// File: rtl/fpu_align_add.sv
// Floating-point add/sub front end: swaps operands by magnitude, aligns the
// smaller significand one bit per cycle, adds, and hands off to a normalizer.
module fpu_align_add #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned EXP_WIDTH = 5,
    parameter int unsigned SIG_WIDTH = 10
) (
    input  logic            clock,
    input  logic            reset_n,
    fpu_align_add_if.slave  io
);
    import fpu_align_add_pkg::*;

    localparam int unsigned SW = SIG_WIDTH + 2;
    localparam int unsigned CW = $clog2(SW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          sig_a_q, sig_a_d;
    logic [SW-1:0]          sig_b_q, sig_b_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [CW-1:0]          count_q, count_d;
    logic [EXP_WIDTH-1:0]   adj_exp_q, adj_exp_d;
    logic                   sticky_q, sticky_d;
    logic                   out_sign_q, out_sign_d;
    logic [SIG_WIDTH:0]     ext_sig_q, ext_sig_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [EXP_WIDTH-1:0]   exp_a, exp_b, exp_l, exp_s, exp_diff;
    logic [SW-1:0]          sig_a_in, sig_b_in, sig_l, sig_s;
    logic                   sign_b_eff, sign_l, sign_s, swap;
    logic [CW-1:0]          shift;
    logic [SW:0]            sum;

    // Operand unpack, denormal flush, magnitude swap and clamped shift count
    always_comb begin
        exp_a      = io.a[BIT_WIDTH-2 -: EXP_WIDTH];
        exp_b      = io.b[BIT_WIDTH-2 -: EXP_WIDTH];
        sig_a_in   = (exp_a == '0) ? '0 : {1'b1, io.a[SIG_WIDTH-1:0], 1'b0};
        sig_b_in   = (exp_b == '0) ? '0 : {1'b1, io.b[SIG_WIDTH-1:0], 1'b0};
        sign_b_eff = io.b[BIT_WIDTH-1] ^ (io.op == FPU_SUB);
        swap       = io.b[BIT_WIDTH-2:0] > io.a[BIT_WIDTH-2:0];
        exp_l      = swap ? exp_b      : exp_a;
        exp_s      = swap ? exp_a      : exp_b;
        sig_l      = swap ? sig_b_in   : sig_a_in;
        sig_s      = swap ? sig_a_in   : sig_b_in;
        sign_l     = swap ? sign_b_eff : io.a[BIT_WIDTH-1];
        sign_s     = swap ? io.a[BIT_WIDTH-1] : sign_b_eff;
        exp_diff   = exp_l - exp_s;
        shift      = (32'(exp_diff) > SW) ? CW'(SW) : CW'(exp_diff);
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        sig_a_d    = sig_a_q;
        sig_b_d    = sig_b_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        count_d    = count_q;
        adj_exp_d  = adj_exp_q;
        sticky_d   = sticky_q;
        out_sign_d = out_sign_q;
        ext_sig_d  = ext_sig_q;
        sum        = '0;

        case (state_q)
            IDLE: begin
                if (io.inValid) begin
                    sig_a_d   = sig_l;
                    sig_b_d   = sig_s;
                    sign_a_d  = sign_l;
                    sign_b_d  = sign_s;
                    count_d   = shift;
                    adj_exp_d = exp_l;
                    sticky_d  = 1'b0;
                    state_d   = (shift == '0) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                sig_b_d  = sig_b_q >> 1;
                sticky_d = sticky_q | sig_b_q[0];
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                // A holds the larger magnitude, so the difference is never negative
                if (sign_a_q == sign_b_q) begin
                    sum = {1'b0, sig_a_q} + {1'b0, sig_b_q};
                end else begin
                    sum = {1'b0, sig_a_q} - {1'b0, sig_b_q};
                end
                ext_sig_d  = sum[SW:2];
                sticky_d   = sticky_q | sum[1] | sum[0];
                out_sign_d = (sum == '0) ? 1'b0 : sign_a_q;
                state_d    = DONE;
            end
            DONE: begin
                if (io.outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sig_a_q     <= '0;
            sig_b_q     <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            count_q     <= '0;
            adj_exp_q   <= '0;
            sticky_q    <= 1'b0;
            out_sign_q  <= 1'b0;
            ext_sig_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_a_q     <= sig_a_d;
            sig_b_q     <= sig_b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            count_q     <= count_d;
            adj_exp_q   <= adj_exp_d;
            sticky_q    <= sticky_d;
            out_sign_q  <= out_sign_d;
            ext_sig_q   <= ext_sig_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.inReady   = in_ready_q;
    assign io.outValid  = out_valid_q;
    assign io.outSign   = out_sign_q;
    assign io.extSigOut = ext_sig_q;
    assign io.adjExp    = adj_exp_q;
    assign io.sticky    = sticky_q;
endmodule

// File: tb/tb_fpu_align_add.sv
// Scoreboard bench for fpu_align_add: directed half-precision vectors, with
// expected results queued at issue and checked by an output monitor.
module tb_fpu_align_add;
    import fpu_align_add_pkg::*;

    typedef struct {
        logic [10:0] ext;
        logic [4:0]  adj;
        logic        sign;
        logic        stk;
        int          lat;
        int          hs_cyc;
        string       name;
    } exp_t;

    logic clock;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;
    int   rise_cyc;
    logic prev_v;
    exp_t exp_q[$];

    fpu_align_add_if #(.BIT_WIDTH(16), .EXP_WIDTH(5), .SIG_WIDTH(10)) bus ();

    fpu_align_add dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Monitor: latency measured from the cycle the handshake was presented
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.outValid && !prev_v) rise_cyc = cyc;
            prev_v = bus.outValid;
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_outValid", 32'(bus.outValid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_extSigOut"}, 32'(bus.extSigOut), 32'(e.ext));
                    chk({e.name, "_adjExp"},    32'(bus.adjExp),    32'(e.adj));
                    chk({e.name, "_outSign"},   32'(bus.outSign),   32'(e.sign));
                    chk({e.name, "_sticky"},    32'(bus.sticky),    32'(e.stk));
                    chk({e.name, "_latency"},   32'(rise_cyc - e.hs_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic send(input string name, input logic [15:0] a, input logic [15:0] b,
                        input fpuOp_t op, input logic [10:0] ext, input logic [4:0] adj,
                        input logic sign, input logic stk, input int d);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.inReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.inReady) begin
            chk({name, "_inReady_timeout"}, 32'(bus.inReady), 32'd1);
            return;
        end
        bus.a       = a;
        bus.b       = b;
        bus.op      = op;
        bus.inValid = 1'b1;
        e.ext = ext; e.adj = adj; e.sign = sign; e.stk = stk;
        e.lat = d + 2; e.hs_cyc = cyc; e.name = name;
        exp_q.push_back(e);
        @(negedge clock);
        bus.inValid = 1'b0;
        bus.a       = 16'($urandom);
        bus.b       = 16'($urandom);
        bus.op      = fpuOp_t'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        rise_cyc    = 0;
        prev_v      = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.op      = FPU_ADD;
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        #1;
        chk("rst_outValid",  32'(bus.outValid),  32'd0);
        chk("rst_inReady",   32'(bus.inReady),   32'd1);
        chk("rst_extSigOut", 32'(bus.extSigOut), 32'd0);
        chk("rst_adjExp",    32'(bus.adjExp),    32'd0);
        chk("rst_sticky",    32'(bus.sticky),    32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        send("add_1p1",    16'h3C00, 16'h3C00, FPU_ADD, 11'h400, 5'd15, 1'b0, 1'b0, 0);
        send("sub_cancel", 16'h3C00, 16'h3C00, FPU_SUB, 11'h000, 5'd15, 1'b0, 1'b0, 0);
        send("add_d1",     16'h3C00, 16'h3800, FPU_ADD, 11'h300, 5'd15, 1'b0, 1'b0, 1);
        send("sub_swap",   16'h3800, 16'h3C00, FPU_SUB, 11'h100, 5'd15, 1'b1, 1'b0, 1);
        send("clamp12",    16'h7800, 16'h3C00, FPU_ADD, 11'h200, 5'd30, 1'b0, 1'b1, 12);
        send("add_cancel", 16'h3C00, 16'hBC00, FPU_ADD, 11'h000, 5'd15, 1'b0, 1'b0, 0);
        send("trunc_stk",  16'h3E00, 16'h3C01, FPU_ADD, 11'h500, 5'd15, 1'b0, 1'b1, 0);
        send("denorm_b",   16'h0005, 16'h3C00, FPU_ADD, 11'h200, 5'd15, 1'b0, 1'b0, 12);
        send("sub_d3_stk", 16'h4000, 16'h3401, FPU_SUB, 11'h1C0, 5'd16, 1'b0, 1'b1, 3);
        send("neg_a",      16'hC400, 16'h4000, FPU_ADD, 11'h100, 5'd17, 1'b1, 1'b0, 1);
        drain();

        // Backpressure: DONE must hold its outputs while outReady is low
        bus.outReady = 1'b0;
        send("stall", 16'h3C00, 16'h3800, FPU_ADD, 11'h300, 5'd15, 1'b0, 1'b0, 1);
        n = 0;
        while (!bus.outValid && n < 50) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_outValid",  32'(bus.outValid),  32'd1);
            chk("stall_inReady",   32'(bus.inReady),   32'd0);
            chk("stall_extSigOut", 32'(bus.extSigOut), 32'h300);
            chk("stall_adjExp",    32'(bus.adjExp),    32'd15);
            @(negedge clock);
        end
        bus.outReady = 1'b1;
        drain();

        // Reset in the middle of a long alignment discards the operation
        send("rst_mid", 16'h7800, 16'h3C00, FPU_ADD, 11'h200, 5'd30, 1'b0, 1'b1, 12);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_outValid",  32'(bus.outValid),  32'd0);
        chk("midrst_inReady",   32'(bus.inReady),   32'd1);
        chk("midrst_extSigOut", 32'(bus.extSigOut), 32'd0);
        chk("midrst_adjExp",    32'(bus.adjExp),    32'd0);
        chk("midrst_outSign",   32'(bus.outSign),   32'd0);
        chk("midrst_sticky",    32'(bus.sticky),    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("post_rst_outValid", 32'(bus.outValid), 32'd0);
        chk("post_rst_inReady",  32'(bus.inReady),  32'd1);

        send("after_rst", 16'h3C00, 16'h3800, FPU_ADD, 11'h300, 5'd15, 1'b0, 1'b0, 1);
        drain();
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_align_add.md
FPU_ALIGN_ADD -- requirements
Module: fpu_align_add

Interface
REQ-001 Parameter BIT_WIDTH, default 16, total operand width.
REQ-002 Parameter EXP_WIDTH, default 5, exponent field width.
REQ-003 Parameter SIG_WIDTH, default 10, stored fraction width.
REQ-004 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port op  input  fpuOp_t  FPU_ADD or FPU_SUB; sampled at input handshake.
REQ-007 Port a  input  BIT_WIDTH  operand A, IEEE-style {sign, exp, frac}.
REQ-008 Port b  input  BIT_WIDTH  operand B, same format.
REQ-009 Port inValid  input  1  a/b/op valid.
REQ-010 Port inReady  output  1  block can accept; equals (state == IDLE).
REQ-011 Port outValid  output  1  result valid; equals (state == DONE).
REQ-012 Port outReady  input  1  downstream (normalizer stage) accepts result.
REQ-013 Port outSign  output  1  result sign.
REQ-014 Port extSigOut  output  SIG_WIDTH+1  significand for normalizer: bit SIG_WIDTH = carry (value >= 2), bit SIG_WIDTH-1 = hidden-one position.
REQ-015 Port adjExp  output  EXP_WIDTH  larger operand exponent, unadjusted.
REQ-016 Port sticky  output  1  OR of all bits dropped by alignment and output truncation.

Function
REQ-017 States SHALL be IDLE, ALIGN, ADD, DONE; input handshake = inValid && inReady; output handshake = outValid && outReady.
REQ-018 On input handshake: significand = {1, frac, 0} (SIG_WIDTH+2 bits), or all-zero if exp == 0 (denormals flushed to zero).
REQ-019 On input handshake: effective sign of B = signB XOR (op == FPU_SUB).
REQ-020 On input handshake: swap operands so A has larger magnitude (compare exp, then frac); tie keeps A unswapped.
REQ-021 Shift count d = min(expA - expB, SIG_WIDTH+2) after swap; adjExp register = expA.
REQ-022 IDLE -> ALIGN if d != 0, IDLE -> ADD if d == 0, on input handshake; otherwise stay IDLE.
REQ-023 ALIGN: each cycle shift B significand right 1 bit, OR shifted-out bit into sticky, decrement count; go to ADD when count reaches 0 (ALIGN occupies exactly d cycles).
REQ-024 ADD (1 cycle): if signs equal, sum = A + B; else sum = A - B (never negative). sum width SIG_WIDTH+3.
REQ-025 ADD: outSign = sign of A after swap; exact cancellation (sum == 0) forces outSign = 0.
REQ-026 ADD: extSigOut = sum[SIG_WIDTH+2:2]; sticky |= sum[1] | sum[0]. Go to DONE.
REQ-027 DONE: outputs held stable until output handshake, then -> IDLE; no input accepted in DONE.
REQ-028 Latency: outValid rises exactly d+2 cycles after the input handshake edge.
REQ-029 Operands with exp all-ones are processed arithmetically with no special handling; result is unspecified.
REQ-030 a, b, op changes outside input handshake SHALL NOT affect an in-flight result.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, outValid 0, inReady 1, outSign 0, extSigOut 0, adjExp 0, sticky 0, count 0, regardless of state.
REQ-032 Reset asserted mid-ALIGN/ADD/DONE SHALL discard the operation; no outValid pulse after release until a new input handshake.

Verification
REQ-033 a=0x3C00, b=0x3C00, op=FPU_ADD -> outValid 2 cycles later; extSigOut=0x400, adjExp=15, outSign=0, sticky=0.
REQ-034 a=0x3C00, b=0x3C00, op=FPU_SUB -> 2 cycles; extSigOut=0x000, outSign=0, sticky=0.
REQ-035 a=0x3C00, b=0x3800, op=FPU_ADD -> 3 cycles; extSigOut=0x300, adjExp=15, sticky=0.
REQ-036 a=0x3800, b=0x3C00, op=FPU_SUB -> 3 cycles; extSigOut=0x100, adjExp=15, outSign=1.
REQ-037 a=0x7800, b=0x3C00, op=FPU_ADD -> d clamped to 12, 14 cycles; extSigOut=0x200, adjExp=30, sticky=1.
REQ-038 Hold outReady=0 for 5 cycles in DONE -> outputs stable, inReady=0; separately, pulse reset_n low during ALIGN -> outValid=0, inReady=1, outputs zero.
